// File: rtl/card_deal_scheduler.sv
// Card-source scheduler for one Blackjack round: opening P,D,P,D deal, then
// round-robin service of player hits and dealer draws into 5-slot hands.
module card_deal_scheduler #(
  parameter logic [15:0] LFSR_SEED  = 16'hACE1,
  parameter int          MAX_CARDS  = 5,
  parameter int          DECK_CARDS = 52
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       deal_start,
  input  logic       player_req,
  input  logic       dealer_req,
  input  logic       round_clr,
  output logic       card_valid,
  output logic [3:0] card_value,
  output logic       card_dest,
  output logic [2:0] card_slot,
  output logic       busy,
  output logic       player_full,
  output logic       dealer_full,
  output logic       deck_low,
  output logic       req_drop
);

  localparam logic [2:0] MAX_SLOT = 3'(MAX_CARDS);
  localparam logic [5:0] DECK_TH  = 6'(DECK_CARDS);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    INIT_P1 = 3'd1,
    INIT_D1 = 3'd2,
    INIT_P2 = 3'd3,
    INIT_D2 = 3'd4,
    SERVE   = 3'd5
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [15:0] lfsr;
  logic [2:0]  p_slot;
  logic [2:0]  d_slot;
  logic [2:0]  p_slot_nxt;
  logic [2:0]  d_slot_nxt;
  logic        pend_p;
  logic        pend_d;
  logic        pend_p_nxt;
  logic        pend_d_nxt;
  logic        rr_dealer;
  logic        rr_nxt;
  logic [5:0]  deal_cnt;
  logic [5:0]  deal_cnt_nxt;
  logic        grant_p;
  logic        grant_d;
  logic        issue;
  logic        issue_dest;
  logic [2:0]  issue_slot;
  logic        drop;
  logic        p_full;
  logic        d_full;
  logic        can_p;
  logic        can_d;

  // 4-bit LFSR nibble reduced mod 13, then mapped to a Blackjack value (A=11, faces=10)
  function automatic logic [3:0] card_of(input logic [3:0] nib);
    case (nib)
      4'd0, 4'd13: card_of = 4'd11;
      4'd1, 4'd14: card_of = 4'd2;
      4'd2, 4'd15: card_of = 4'd3;
      4'd3:        card_of = 4'd4;
      4'd4:        card_of = 4'd5;
      4'd5:        card_of = 4'd6;
      4'd6:        card_of = 4'd7;
      4'd7:        card_of = 4'd8;
      4'd8:        card_of = 4'd9;
      4'd9:        card_of = 4'd10;
      4'd10, 4'd11, 4'd12: card_of = 4'd10;
      default:     card_of = 4'd0;
    endcase
  endfunction

  function automatic logic [2:0] slot_inc(input logic [2:0] s);
    if (s >= MAX_SLOT) begin
      slot_inc = MAX_SLOT;
    end else begin
      slot_inc = s + 3'd1;
    end
  endfunction

  function automatic logic [15:0] lfsr_step(input logic [15:0] l);
    lfsr_step = {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction

  assign p_full = (p_slot == MAX_SLOT);
  assign d_full = (d_slot == MAX_SLOT);
  assign can_p  = pend_p && !p_full;
  assign can_d  = pend_d && !d_full;

  // Next-state, arbitration and request bookkeeping
  always_comb begin
    state_nxt  = state;
    p_slot_nxt = p_slot;
    d_slot_nxt = d_slot;
    pend_p_nxt = pend_p;
    pend_d_nxt = pend_d;
    rr_nxt     = rr_dealer;
    grant_p    = 1'b0;
    grant_d    = 1'b0;
    issue      = 1'b0;
    issue_dest = 1'b0;
    issue_slot = 3'd0;
    drop       = 1'b0;
    if (round_clr) begin
      state_nxt  = IDLE;
      p_slot_nxt = 3'd0;
      d_slot_nxt = 3'd0;
      pend_p_nxt = 1'b0;
      pend_d_nxt = 1'b0;
      rr_nxt     = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (deal_start) begin
            state_nxt = INIT_P1;
            rr_nxt    = 1'b0;
            grant_p   = 1'b1;
          end else begin
            state_nxt = IDLE;
          end
        end
        INIT_P1: begin
          state_nxt = INIT_D1;
          grant_d   = 1'b1;
        end
        INIT_D1: begin
          state_nxt = INIT_P2;
          grant_p   = 1'b1;
        end
        INIT_P2: begin
          state_nxt = INIT_D2;
          grant_d   = 1'b1;
        end
        INIT_D2: begin
          state_nxt = SERVE;
        end
        SERVE: begin
          // Alternate only under contention; a lone requester never waits
          if (can_p && can_d) begin
            if (rr_dealer) begin
              grant_d = 1'b1;
            end else begin
              grant_p = 1'b1;
            end
            rr_nxt = !rr_dealer;
          end else if (can_p) begin
            grant_p = 1'b1;
          end else if (can_d) begin
            grant_d = 1'b1;
          end else begin
            grant_p = 1'b0;
          end
          if (pend_p) begin
            pend_p_nxt = 1'b0;
            drop       = p_full;
          end else begin
            pend_p_nxt = 1'b0;
          end
          if (pend_d) begin
            pend_d_nxt = 1'b0;
            drop       = drop | d_full;
          end else begin
            pend_d_nxt = 1'b0;
          end
          if (can_p && !grant_p) begin
            pend_p_nxt = 1'b1;
          end else begin
            pend_p_nxt = pend_p_nxt;
          end
          if (can_d && !grant_d) begin
            pend_d_nxt = 1'b1;
          end else begin
            pend_d_nxt = pend_d_nxt;
          end
        end
        default: begin
          state_nxt = IDLE;
        end
      endcase

      if (grant_p) begin
        issue      = 1'b1;
        issue_dest = 1'b0;
        issue_slot = p_slot;
        p_slot_nxt = slot_inc(p_slot);
      end else if (grant_d) begin
        issue      = 1'b1;
        issue_dest = 1'b1;
        issue_slot = d_slot;
        d_slot_nxt = slot_inc(d_slot);
      end else begin
        issue = 1'b0;
      end

      // New requests are queued last so they merge with, or re-arm, a pending flag
      if (state == IDLE) begin
        drop = drop | player_req | dealer_req;
      end else begin
        if (player_req) begin
          if (p_full) begin
            drop = 1'b1;
          end else begin
            pend_p_nxt = 1'b1;
          end
        end else begin
          pend_p_nxt = pend_p_nxt;
        end
        if (dealer_req) begin
          if (d_full) begin
            drop = 1'b1;
          end else begin
            pend_d_nxt = 1'b1;
          end
        end else begin
          pend_d_nxt = pend_d_nxt;
        end
        if (deal_start) begin
          drop = 1'b1;
        end else begin
          drop = drop;
        end
      end
    end
  end

  // Saturating dealt-card counter update
  always_comb begin
    if (issue && (deal_cnt != 6'd63)) begin
      deal_cnt_nxt = deal_cnt + 6'd1;
    end else begin
      deal_cnt_nxt = deal_cnt;
    end
  end

  // State, counters and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      lfsr        <= LFSR_SEED;
      p_slot      <= 3'd0;
      d_slot      <= 3'd0;
      pend_p      <= 1'b0;
      pend_d      <= 1'b0;
      rr_dealer   <= 1'b0;
      deal_cnt    <= 6'd0;
      card_valid  <= 1'b0;
      card_value  <= 4'd0;
      card_dest   <= 1'b0;
      card_slot   <= 3'd0;
      busy        <= 1'b0;
      player_full <= 1'b0;
      dealer_full <= 1'b0;
      deck_low    <= 1'b0;
      req_drop    <= 1'b0;
    end else begin
      state       <= state_nxt;
      lfsr        <= lfsr_step(lfsr);
      p_slot      <= p_slot_nxt;
      d_slot      <= d_slot_nxt;
      pend_p      <= pend_p_nxt;
      pend_d      <= pend_d_nxt;
      rr_dealer   <= rr_nxt;
      deal_cnt    <= deal_cnt_nxt;
      card_valid  <= issue;
      card_value  <= issue ? card_of(lfsr[3:0]) : 4'd0;
      card_dest   <= issue ? issue_dest : 1'b0;
      card_slot   <= issue ? issue_slot : 3'd0;
      busy        <= (state_nxt == INIT_P1) || (state_nxt == INIT_D1) ||
                     (state_nxt == INIT_P2) || (state_nxt == INIT_D2) ||
                     pend_p_nxt || pend_d_nxt;
      player_full <= (p_slot_nxt == MAX_SLOT);
      dealer_full <= (d_slot_nxt == MAX_SLOT);
      deck_low    <= deck_low || (deal_cnt_nxt >= DECK_TH);
      req_drop    <= drop;
    end
  end

endmodule

// File: tb/tb_card_deal_scheduler.sv
// Self-checking bench for card_deal_scheduler: directed scenarios with random
// gaps and hit counts, card values checked against a behavioural LFSR/deck model.
module tb_card_deal_scheduler;

  localparam logic [15:0] SEED = 16'hACE1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       deal_start = 1'b0;
  logic       player_req = 1'b0;
  logic       dealer_req = 1'b0;
  logic       round_clr = 1'b0;
  logic       card_valid;
  logic [3:0] card_value;
  logic       card_dest;
  logic [2:0] card_slot;
  logic       busy;
  logic       player_full;
  logic       dealer_full;
  logic       deck_low;
  logic       req_drop;

  int checks = 0;
  int errors = 0;

  logic [15:0] mdl;
  logic [15:0] mdl_prev;

  card_deal_scheduler dut (
    .clk(clk), .rst(rst), .deal_start(deal_start), .player_req(player_req),
    .dealer_req(dealer_req), .round_clr(round_clr), .card_valid(card_valid),
    .card_value(card_value), .card_dest(card_dest), .card_slot(card_slot),
    .busy(busy), .player_full(player_full), .dealer_full(dealer_full),
    .deck_low(deck_low), .req_drop(req_drop)
  );

  always #5 clk = ~clk;

  // Polynomial x^16+x^14+x^13+x^11: feedback is the XOR of the tapped exponents
  function automatic logic [15:0] lfsr_adv(input logic [15:0] l);
    int   taps [4];
    logic fb;
    taps = '{16, 14, 13, 11};
    fb = 1'b0;
    foreach (taps[i]) fb = fb ^ l[taps[i]-1];
    return {l[14:0], fb};
  endfunction

  function automatic int exp_val(input logic [15:0] l);
    int r;
    r = int'(l[3:0]) % 13;
    if (r == 0) return 11;
    else if (r <= 9) return r + 1;
    else return 10;
  endfunction

  // mdl_prev holds the LFSR of the cycle just before the latest edge (the grant cycle)
  always @(posedge clk) begin
    mdl_prev <= mdl;
    mdl      <= rst ? SEED : lfsr_adv(mdl);
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic new_round();
    round_clr = 1'b1;
    step();
    round_clr = 1'b0;
    deal_start = 1'b1;
    step();
    deal_start = 1'b0;
    repeat (4) step();
  endtask

  task automatic test_reset();
    step();
    step();
    checks++;
    if ({card_valid, card_value, card_dest, card_slot, busy, player_full,
         dealer_full, deck_low, req_drop} !== 15'd0) begin
      errors++;
      $display("FAIL reset_outputs got %b exp 0", {card_valid, card_value, card_dest,
               card_slot, busy, player_full, dealer_full, deck_low, req_drop});
    end
    rst = 1'b0;
  endtask

  task automatic test_deal();
    repeat ($urandom_range(0, 4)) step();
    deal_start = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      deal_start = 1'b0;
      checks++;
      if (card_valid !== 1'b1 || card_dest !== 1'(i % 2) || card_slot !== 3'(i / 2) ||
          busy !== 1'b1) begin
        errors++;
        $display("FAIL deal_card%0d got v=%b d=%b s=%0d b=%b exp v=1 d=%0d s=%0d b=1",
                 i, card_valid, card_dest, card_slot, busy, i % 2, i / 2);
      end
      checks++;
      if (int'(card_value) != exp_val(mdl_prev) || card_value < 4'd2 || card_value > 4'd11) begin
        errors++;
        $display("FAIL deal_value%0d got %0d exp %0d", i, card_value, exp_val(mdl_prev));
      end
    end
    step();
    checks++;
    if (card_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL deal_end got v=%b b=%b exp 0 0", card_valid, busy);
    end
  endtask

  task automatic test_both_req();
    player_req = 1'b1;
    dealer_req = 1'b1;
    step();
    player_req = 1'b0;
    dealer_req = 1'b0;
    checks++;
    if (card_valid !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL both_pending got v=%b b=%b exp 0 1", card_valid, busy);
    end
    for (int i = 0; i < 2; i++) begin
      step();
      checks++;
      if (card_valid !== 1'b1 || card_dest !== 1'(i) || card_slot !== 3'd2 ||
          int'(card_value) != exp_val(mdl_prev)) begin
        errors++;
        $display("FAIL both_card%0d got v=%b d=%b s=%0d val=%0d exp v=1 d=%0d s=2 val=%0d",
                 i, card_valid, card_dest, card_slot, card_value, i, exp_val(mdl_prev));
      end
    end
    step();
    checks++;
    if (card_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL both_end got v=%b b=%b exp 0 0", card_valid, busy);
    end
  endtask

  task automatic test_player_hits();
    new_round();
    for (int h = 0; h < 3; h++) begin
      repeat ($urandom_range(0, 3)) step();
      player_req = 1'b1;
      step();
      player_req = 1'b0;
      step();
      checks++;
      if (card_valid !== 1'b1 || card_dest !== 1'b0 || card_slot !== 3'(2 + h) ||
          int'(card_value) != exp_val(mdl_prev) || player_full !== (h == 2)) begin
        errors++;
        $display("FAIL hit%0d got v=%b d=%b s=%0d val=%0d full=%b exp v=1 d=0 s=%0d val=%0d full=%0d",
                 h, card_valid, card_dest, card_slot, card_value, player_full, 2 + h,
                 exp_val(mdl_prev), h == 2);
      end
    end
    player_req = 1'b1;
    step();
    player_req = 1'b0;
    checks++;
    if (req_drop !== 1'b1 || card_valid !== 1'b0) begin
      errors++;
      $display("FAIL full_drop got drop=%b v=%b exp 1 0", req_drop, card_valid);
    end
    step();
    checks++;
    if (req_drop !== 1'b0 || card_valid !== 1'b0 || player_full !== 1'b1) begin
      errors++;
      $display("FAIL full_after got drop=%b v=%b full=%b exp 0 0 1", req_drop, card_valid, player_full);
    end
  endtask

  task automatic test_clr_with_req();
    round_clr = 1'b1;
    dealer_req = 1'b1;
    step();
    round_clr = 1'b0;
    dealer_req = 1'b0;
    checks++;
    if (card_valid !== 1'b0 || busy !== 1'b0 || player_full !== 1'b0 ||
        dealer_full !== 1'b0 || req_drop !== 1'b0) begin
      errors++;
      $display("FAIL clr_state got v=%b b=%b pf=%b df=%b drop=%b exp all 0",
               card_valid, busy, player_full, dealer_full, req_drop);
    end
    step();
    checks++;
    if (card_valid !== 1'b0) begin
      errors++;
      $display("FAIL clr_nocard got v=%b exp 0", card_valid);
    end
    player_req = 1'b1;
    step();
    player_req = 1'b0;
    checks++;
    if (req_drop !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_drop got drop=%b b=%b exp 1 0", req_drop, busy);
    end
    deal_start = 1'b1;
    step();
    deal_start = 1'b0;
    checks++;
    if (card_valid !== 1'b1 || card_dest !== 1'b0 || card_slot !== 3'd0) begin
      errors++;
      $display("FAIL clr_slot0 got v=%b d=%b s=%0d exp 1 0 0", card_valid, card_dest, card_slot);
    end
    repeat (4) step();
  endtask

  task automatic test_req_during_init();
    round_clr = 1'b1;
    step();
    round_clr = 1'b0;
    deal_start = 1'b1;
    step();
    deal_start = 1'b0;
    step();
    player_req = 1'b1;
    step();
    player_req = 1'b0;
    step();
    step();
    checks++;
    if (card_valid !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL init_pending got v=%b b=%b exp 0 1", card_valid, busy);
    end
    step();
    checks++;
    if (card_valid !== 1'b1 || card_dest !== 1'b0 || card_slot !== 3'd2 ||
        int'(card_value) != exp_val(mdl_prev)) begin
      errors++;
      $display("FAIL init_served got v=%b d=%b s=%0d val=%0d exp 1 0 2 %0d",
               card_valid, card_dest, card_slot, card_value, exp_val(mdl_prev));
    end
  endtask

  task automatic test_rst_mid_deal();
    round_clr = 1'b1;
    step();
    round_clr = 1'b0;
    deal_start = 1'b1;
    step();
    deal_start = 1'b0;
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if ({card_valid, card_value, card_dest, card_slot, busy, player_full,
         dealer_full, deck_low, req_drop} !== 15'd0) begin
      errors++;
      $display("FAIL rst_mid got %b exp 0", {card_valid, card_value, card_dest,
               card_slot, busy, player_full, dealer_full, deck_low, req_drop});
    end
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (card_valid !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL rst_quiet%0d got v=%b b=%b exp 0 0", i, card_valid, busy);
      end
    end
  endtask

  task automatic test_deck();
    int count;
    int np;
    int nd;
    rst = 1'b1;
    step();
    rst = 1'b0;
    count = 0;
    for (int r = 0; r < 12 && count < 60; r++) begin
      round_clr = 1'b1;
      step();
      round_clr = 1'b0;
      deal_start = 1'b1;
      for (int i = 0; i < 4; i++) begin
        step();
        deal_start = 1'b0;
        count++;
        checks++;
        if (card_valid !== 1'b1 || card_slot !== 3'(i / 2) ||
            int'(card_value) != exp_val(mdl_prev) || deck_low !== (count >= 52)) begin
          errors++;
          $display("FAIL deck_deal n=%0d got v=%b s=%0d val=%0d low=%b exp 1 %0d %0d %0d",
                   count, card_valid, card_slot, card_value, deck_low, i / 2,
                   exp_val(mdl_prev), count >= 52);
        end
      end
      step();
      np = $urandom_range(0, 3);
      nd = $urandom_range(1, 3);
      for (int h = 0; h < np + nd; h++) begin
        if (h < np) player_req = 1'b1;
        else dealer_req = 1'b1;
        step();
        player_req = 1'b0;
        dealer_req = 1'b0;
        step();
        count++;
        checks++;
        if (card_valid !== 1'b1 || card_dest !== (h >= np) ||
            card_slot !== 3'(2 + ((h < np) ? h : h - np)) ||
            int'(card_value) != exp_val(mdl_prev) || deck_low !== (count >= 52)) begin
          errors++;
          $display("FAIL deck_hit n=%0d got v=%b d=%b s=%0d val=%0d low=%b exp 1 %0d %0d %0d %0d",
                   count, card_valid, card_dest, card_slot, card_value, deck_low, h >= np,
                   2 + ((h < np) ? h : h - np), exp_val(mdl_prev), count >= 52);
        end
      end
    end
    round_clr = 1'b1;
    step();
    round_clr = 1'b0;
    step();
    checks++;
    if (deck_low !== 1'b1) begin
      errors++;
      $display("FAIL deck_sticky got %b exp 1", deck_low);
    end
  endtask

  initial begin
    test_reset();
    test_deal();
    test_both_req();
    test_player_hits();
    test_clr_with_req();
    test_req_during_init();
    test_rst_mid_deal();
    test_deal();
    test_deck();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
